scroll_pixel_gen: RTL and testbench

SCROLL_PIXEL_GEN -- requirements
Module: scroll_pixel_gen

---
 rtl/screen_pkg.sv | 18 +
 rtl/scroll_offset_ctrl.sv | 57 +++++
 rtl/scroll_pixel_gen.sv | 98 +++++++++
 tb/tb_scroll_pixel_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Shared screen geometry, pixel format and scroll FSM encoding for the
// scrolling pixel generator.
package screen_pkg;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int ADDR_W = 17;
  localparam int PIX_W  = 12;
  localparam int OFS_W  = 9;

  localparam logic [PIX_W-1:0] BORDER_COLOR = 12'hFFF;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } scroll_state_t;

endpackage

// File: rtl/scroll_offset_ctrl.sv
// Scroll request FSM and horizontal offset register; a pending request is
// applied only on frame_start so the offset stays constant across a frame.
module scroll_offset_ctrl
  import screen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             scroll_tick,
  input  logic             scroll_en,
  input  logic             scroll_dir,
  output logic [OFS_W-1:0] offset
);

  scroll_state_t state;
  scroll_state_t state_next;
  logic          step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A tick landing on the frame that consumes a request re-arms PEND.
  always_comb begin
    state_next = state;
    if (!scroll_en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (scroll_tick) state_next = PEND;
        PEND: if (frame_start && !scroll_tick) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    step = scroll_en && (state == PEND) && frame_start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      offset <= '0;
    end else if (step) begin
      if (scroll_dir) begin
        offset <= (offset == '0) ? OFS_W'(IMG_W - 1) : offset - OFS_W'(1);
      end else begin
        offset <= (offset == OFS_W'(IMG_W - 1)) ? '0 : offset + OFS_W'(1);
      end
    end
  end

endmodule

// File: rtl/scroll_pixel_gen.sv
// 2x-upscaled, horizontally scrolling 320x240 image source with 2-cycle latency.
// Optional screen-fixed white border: define SCROLL_PIXEL_BORDER_EN.
module scroll_pixel_gen
  import screen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              valid,
  input  logic              scroll_tick,
  input  logic              scroll_en,
  input  logic              scroll_dir,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [PIX_W-1:0]  pixel,
  output logic              pixel_valid,
  output logic [OFS_W-1:0]  offset
);

  logic [8:0]        src_x;
  logic [8:0]        src_y;
  logic              unused_lsb;
  logic              frame_start;
  logic [9:0]        col_sum;
  logic [8:0]        col;
  logic [ADDR_W-1:0] addr_next;
  logic              valid_d1;

  assign src_x       = h_cnt[9:1];
  assign src_y       = v_cnt[9:1];
  assign unused_lsb  = h_cnt[0] ^ v_cnt[0];
  assign frame_start = valid && (h_cnt == 10'd0) && (v_cnt == 10'd0);

  scroll_offset_ctrl u_offset_ctrl (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .scroll_tick (scroll_tick),
    .scroll_en   (scroll_en),
    .scroll_dir  (scroll_dir),
    .offset      (offset)
  );

  // Column wraps with a single conditional subtract since both terms are < 320.
  always_comb begin
    col_sum   = {1'b0, src_x} + {1'b0, offset};
    col       = col_sum[8:0];
    if (col_sum >= 10'(IMG_W)) begin
      col = 9'(col_sum - 10'(IMG_W));
    end
    addr_next = ({8'd0, src_y} << 8) + ({8'd0, src_y} << 6) + {8'd0, col};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_addr  <= '0;
      valid_d1    <= 1'b0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_addr  <= addr_next;
      valid_d1    <= valid;
      pixel_valid <= valid_d1;
    end
  end

`ifdef SCROLL_PIXEL_BORDER_EN
  logic border_d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      border_d1 <= 1'b0;
    end else begin
      border_d1 <= (src_x == 9'd0) || (src_x == 9'(IMG_W - 1)) ||
                   (src_y == 9'd0) || (src_y == 9'(IMG_H - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel <= '0;
    end else if (valid_d1) begin
      pixel <= border_d1 ? BORDER_COLOR : mem_data;
    end else begin
      pixel <= '0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel <= '0;
    end else begin
      pixel <= valid_d1 ? mem_data : '0;
    end
  end
`endif

endmodule

// File: tb/tb_scroll_pixel_gen.sv
// Self-checking bench for scroll_pixel_gen: directed steps, scoreboard queues
// for address/pixel expectations and a reference model of the scroll offset.
module tb_scroll_pixel_gen;
  import screen_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic              valid;
  logic              scroll_tick;
  logic              scroll_en;
  logic              scroll_dir;
  logic [PIX_W-1:0]  mem_data;
  logic [ADDR_W-1:0] pixel_addr;
  logic [PIX_W-1:0]  pixel;
  logic              pixel_valid;
  logic [OFS_W-1:0]  offset;

  int n_assert = 0;
  int n_fail   = 0;
  int m_off    = 0;
  bit m_pend   = 1'b0;

  logic [ADDR_W-1:0] addr_q[$];
  logic [PIX_W:0]    pix_q[$];

  scroll_pixel_gen dut (
    .clk         (clk),
    .rst         (rst),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .valid       (valid),
    .scroll_tick (scroll_tick),
    .scroll_en   (scroll_en),
    .scroll_dir  (scroll_dir),
    .mem_data    (mem_data),
    .pixel_addr  (pixel_addr),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .offset      (offset)
  );

  always #20 clk = ~clk;

  function automatic int next_off(input int o, input logic dir);
    if (dir) return (o == 0) ? IMG_W - 1 : o - 1;
    return (o == IMG_W - 1) ? 0 : o + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: update the offset model from the inputs seen at this edge.
  task automatic tick_clock();
    bit fs;
    fs = valid && (h_cnt == 10'd0) && (v_cnt == 10'd0);
    @(posedge clk);
    if (rst) begin
      m_off  = 0;
      m_pend = 1'b0;
    end else if (!scroll_en) begin
      m_pend = 1'b0;
    end else if (!m_pend) begin
      m_pend = scroll_tick;
    end else if (fs) begin
      m_off  = next_off(m_off, scroll_dir);
      m_pend = scroll_tick;
    end
    #1;
  endtask

  task automatic idle_inputs();
    valid       = 1'b0;
    h_cnt       = 10'd100;
    v_cnt       = 10'd100;
    scroll_tick = 1'b0;
  endtask

  task automatic frame_cycle(input logic tk);
    valid       = 1'b1;
    h_cnt       = 10'd0;
    v_cnt       = 10'd0;
    scroll_tick = tk;
    tick_clock();
    idle_inputs();
  endtask

  task automatic scroll_step(input logic dir, input int ticks);
    scroll_dir = dir;
    idle_inputs();
    repeat (ticks) begin
      scroll_tick = 1'b1;
      tick_clock();
    end
    scroll_tick = 1'b0;
    frame_cycle(1'b0);
  endtask

  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v,
                               input logic vld, input logic [PIX_W-1:0] mem);
    int sx;
    int sy;
    logic [PIX_W-1:0] exp_pix;
    logic [PIX_W:0]   exp_entry;
    sx = int'(h) / 2;
    sy = int'(v) / 2;
    exp_pix = mem;
`ifdef SCROLL_PIXEL_BORDER_EN
    if (sx == 0 || sx == IMG_W - 1 || sy == 0 || sy == IMG_H - 1) exp_pix = 12'hFFF;
`endif
    if (!vld) exp_pix = '0;
    addr_q.push_back(ADDR_W'(sy * IMG_W + (sx + m_off) % IMG_W));
    pix_q.push_back({vld, exp_pix});
    h_cnt = h;
    v_cnt = v;
    valid = vld;
    scroll_tick = 1'b0;
    tick_clock();
    checkOutput("pixel_addr", 32'(pixel_addr), 32'(addr_q.pop_front()));
    idle_inputs();
    mem_data = mem;
    tick_clock();
    exp_entry = pix_q.pop_front();
    checkOutput("pixel", 32'(pixel), 32'(exp_entry[PIX_W-1:0]));
    checkOutput("pixel_valid", 32'(pixel_valid), 32'(exp_entry[PIX_W]));
    mem_data = '0;
  endtask

  initial begin
    rst        = 1'b1;
    scroll_en  = 1'b0;
    scroll_dir = 1'b0;
    mem_data   = '0;
    idle_inputs();
    tick_clock();
    tick_clock();
    checkOutput("reset_offset", 32'(offset), 32'd0);
    checkOutput("reset_addr", 32'(pixel_addr), 32'd0);
    checkOutput("reset_pixel", 32'(pixel), 32'd0);
    checkOutput("reset_pixel_valid", 32'(pixel_valid), 32'd0);
    rst       = 1'b0;
    scroll_en = 1'b1;
    tick_clock();

    $display("[TB] pipeline checks");
    applyStimulus(10'd5, 10'd7, 1'b1, 12'hABC);
    applyStimulus(10'd639, 10'd479, 1'b1, 12'h123);
    applyStimulus(10'd300, 10'd200, 1'b0, 12'h456);

    $display("[TB] coalescing and wrap");
    scroll_step(1'b1, 3);
    checkOutput("wrap_down", 32'(offset), 32'd319);
    scroll_step(1'b0, 3);
    checkOutput("wrap_up", 32'(offset), 32'd0);
    repeat (10) scroll_step(1'b1, 1);
    checkOutput("offset_310", 32'(offset), 32'd310);
    applyStimulus(10'd40, 10'd0, 1'b1, 12'h321);

    $display("[TB] tick coincident with frame_start");
    scroll_dir  = 1'b1;
    scroll_tick = 1'b1;
    tick_clock();
    frame_cycle(1'b1);
    checkOutput("pend_tick_step", 32'(offset), 32'd309);
    frame_cycle(1'b0);
    checkOutput("pend_second_step", 32'(offset), 32'd308);
    frame_cycle(1'b0);
    checkOutput("idle_hold", 32'(offset), 32'd308);
    frame_cycle(1'b1);
    checkOutput("idle_tick_no_step", 32'(offset), 32'd308);
    frame_cycle(1'b0);
    checkOutput("idle_tick_next", 32'(offset), 32'd307);

    $display("[TB] border region");
    applyStimulus(10'd0, 10'd100, 1'b1, 12'h5A5);
    applyStimulus(10'd200, 10'd100, 1'b1, 12'h5A5);

    $display("[TB] mid-line reset");
    while (m_off != 100) scroll_step(1'b1, 1);
    checkOutput("offset_100", 32'(offset), 32'd100);
    valid    = 1'b1;
    h_cnt    = 10'd100;
    v_cnt    = 10'd50;
    mem_data = 12'hABC;
    tick_clock();
    rst = 1'b1;
    tick_clock();
    checkOutput("midreset_offset", 32'(offset), 32'd0);
    checkOutput("midreset_pixel", 32'(pixel), 32'd0);
    checkOutput("midreset_pixel_valid", 32'(pixel_valid), 32'd0);
    rst = 1'b0;
    idle_inputs();
    mem_data = '0;
    tick_clock();
    applyStimulus(10'd0, 10'd0, 1'b1, 12'h555);
    applyStimulus(10'd2, 10'd4, 1'b1, 12'h777);

    $display("[TB] scroll enable");
    scroll_step(1'b0, 1);
    checkOutput("enabled_step", 32'(offset), 32'd1);
    scroll_en = 1'b0;
    repeat (3) scroll_step(1'b0, 2);
    checkOutput("disabled_hold", 32'(offset), 32'd1);
    scroll_en   = 1'b1;
    scroll_tick = 1'b1;
    tick_clock();
    scroll_tick = 1'b0;
    scroll_en   = 1'b0;
    tick_clock();
    scroll_en = 1'b1;
    frame_cycle(1'b0);
    checkOutput("disable_clears_pend", 32'(offset), 32'd1);
    checkOutput("model_agrees", 32'(offset), 32'(m_off));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
